// File: rtl/target_gen.sv
// target_gen: free-running Galois LFSR reduced into [TMIN, TMAX], never repeating the previous target.
// Define TARGET_GEN_BCD_EN to add registered bcd_tens/bcd_ones outputs.
module target_gen #(
    parameter int          TMIN = 1,
    parameter int          TMAX = 99,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       busy,
    output logic       valid,
`ifdef TARGET_GEN_BCD_EN
    output logic [6:0] target,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones
`else
    output logic [6:0] target
`endif
);

    localparam logic [7:0]  RANGE = 8'(TMAX - TMIN + 1);
    localparam logic [6:0]  TMIN7 = 7'(TMIN);
    localparam logic [6:0]  TMAX7 = 7'(TMAX);
    localparam logic [15:0] TAPS  = 16'hB400;

    typedef enum logic [1:0] {IDLE, REDUCE, ADJUST, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] lfsr;
    logic [15:0] shreg;
    logic [6:0]  rem;
    logic [6:0]  rem_next;
    logic [3:0]  bit_cnt;
    logic [7:0]  trial;
    logic [6:0]  cand;
    logic [6:0]  target_next;

    // Right-shifting Galois form; a nonzero seed keeps it out of the all-zero lock-up state.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = REDUCE;
            REDUCE:  if (bit_cnt == 4'd15) state_next = ADJUST;
            ADJUST:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One restoring step: the partial remainder is always below RANGE, so trial fits in 8 bits.
    always_comb begin
        trial = {rem, shreg[15]};
        if (trial >= RANGE)
            rem_next = 7'(trial - RANGE);
        else
            rem_next = trial[6:0];
    end

    always_comb begin
        cand        = rem + TMIN7;
        target_next = cand;
        if (cand == target && target != 7'd0)
            target_next = (target == TMAX7) ? TMIN7 : target + 7'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= 16'h0000;
            rem     <= 7'd0;
            bit_cnt <= 4'd0;
            target  <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        shreg   <= lfsr;
                        rem     <= 7'd0;
                        bit_cnt <= 4'd0;
                    end
                end
                REDUCE: begin
                    shreg   <= {shreg[14:0], 1'b0};
                    rem     <= rem_next;
                    bit_cnt <= bit_cnt + 4'd1;
                end
                ADJUST:  target <= target_next;
                default: ;
            endcase
        end
    end

    assign busy  = (state == REDUCE) || (state == ADJUST);
    assign valid = (state == DONE);

`ifdef TARGET_GEN_BCD_EN
    // Repeated subtraction of ten with a fixed bound; targets never exceed 99.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] r;
        logic [3:0] t;
        r = v;
        t = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
        end else if (state == ADJUST) begin
            {bcd_tens, bcd_ones} <= to_bcd(target_next);
        end
    end
`endif

endmodule

// File: tb/tb_target_gen.sv
// tb_target_gen: directed checks of target_gen with default range and a two-value range instance.
module tb_target_gen;

    logic       clk;
    logic       rst;
    logic       req;
    logic       busy;
    logic       valid;
    logic [6:0] target;
    logic       rst_b;
    logic       req_b;
    logic       busy_b;
    logic       valid_b;
    logic [6:0] target_b;
`ifdef TARGET_GEN_BCD_EN
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens_b;
    logic [3:0] bcd_ones_b;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] m_lfsr;

    target_gen dut (
        .clk(clk), .rst(rst), .req(req), .busy(busy), .valid(valid),
`ifdef TARGET_GEN_BCD_EN
        .target(target), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones)
`else
        .target(target)
`endif
    );

    target_gen #(.TMIN(1), .TMAX(2), .SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .busy(busy_b), .valid(valid_b),
`ifdef TARGET_GEN_BCD_EN
        .target(target_b), .bcd_tens(bcd_tens_b), .bcd_ones(bcd_ones_b)
`else
        .target(target_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR for the default instance: x^16+x^14+x^13+x^11+1, right-shifting Galois.
    always @(posedge clk) begin
        if (rst)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    function automatic logic [6:0] ref_target(input logic [15:0] cap, input logic [6:0] prev,
                                              input int tmin, input int tmax);
        int c;
        int p;
        p = int'({25'd0, prev});
        c = int'({16'd0, cap}) % (tmax - tmin + 1) + tmin;
        if (p != 0 && c == p)
            c = (p == tmax) ? tmin : p + 1;
        return 7'(c);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns the edge count at which valid was first seen, or 0 if it never came.
    task automatic wait_valid(input bit which, output int n);
        bit seen;
        n    = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            tick();
            if (!which) req = 1'b0;
            if ((which ? valid_b : valid) === 1'b1) begin
                n    = i;
                seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0;
        tick();
        req = 1'b1;
        tick();
        compared++;
        if (target !== 7'd0) begin mismatched++; $display("[TB] FAIL reset_target got=%0d want=0", target); end
        compared++;
        if (valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_over_req got=%b want=0", busy); end
`ifdef TARGET_GEN_BCD_EN
        compared++;
        if ({bcd_tens, bcd_ones} !== 8'h00) begin
            mismatched++; $display("[TB] FAIL reset_bcd got=%h want=00", {bcd_tens, bcd_ones});
        end
`endif
    endtask

    task automatic test_first_request;
        int n;
        rst = 1'b0; req = 1'b1;
        compared++;
        if (m_lfsr !== 16'hACE1) begin mismatched++; $display("[TB] FAIL model_seed got=%h want=ace1", m_lfsr); end
        wait_valid(1'b0, n);
        compared++;
        if (n != 18) begin mismatched++; $display("[TB] FAIL first_latency got=%0d want=18", n); end
        compared++;
        if (target !== 7'd5) begin mismatched++; $display("[TB] FAIL first_target got=%0d want=5", target); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_in_done got=%b want=0", busy); end
`ifdef TARGET_GEN_BCD_EN
        compared++;
        if ({bcd_tens, bcd_ones} !== 8'h05) begin
            mismatched++; $display("[TB] FAIL first_bcd got=%h want=05", {bcd_tens, bcd_ones});
        end
`endif
        tick();
        compared++;
        if (valid !== 1'b0) begin mismatched++; $display("[TB] FAIL valid_width got=%b want=0", valid); end
        compared++;
        if (target !== 7'd5) begin mismatched++; $display("[TB] FAIL target_hold got=%0d want=5", target); end
    endtask

    task automatic test_ignored_req;
        logic [6:0] exp;
        int  vcount;
        int  vfirst;
        bit  busy_ok;
        bit  hold_ok;
        req = 1'b1;
        exp = ref_target(m_lfsr, 7'd5, 1, 99);
        vcount = 0; vfirst = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            tick();
            req = (n == 2 || n == 9 || n == 18);
            if (n <= 17 && busy !== 1'b1) busy_ok = 1'b0;
            if ((n == 19 || n == 20) && busy !== 1'b0) busy_ok = 1'b0;
            if (n < 18 && target !== 7'd5) hold_ok = 1'b0;
            if (valid === 1'b1) begin
                vcount++;
                if (vfirst == 0) vfirst = n;
            end
        end
        compared++;
        if (!busy_ok) begin mismatched++; $display("[TB] FAIL ignored_busy got=0 want=1"); end
        compared++;
        if (vcount != 1) begin mismatched++; $display("[TB] FAIL ignored_valid_count got=%0d want=1", vcount); end
        compared++;
        if (vfirst != 18) begin mismatched++; $display("[TB] FAIL ignored_latency got=%0d want=18", vfirst); end
        compared++;
        if (!hold_ok) begin mismatched++; $display("[TB] FAIL ignored_target_hold got=0 want=1"); end
        compared++;
        if (target !== exp) begin mismatched++; $display("[TB] FAIL ignored_target got=%0d want=%0d", target, exp); end
`ifdef TARGET_GEN_BCD_EN
        compared++;
        if (bcd_tens !== 4'(exp / 10) || bcd_ones !== 4'(exp % 10)) begin
            mismatched++; $display("[TB] FAIL ignored_bcd got=%0d%0d want=%0d", bcd_tens, bcd_ones, exp);
        end
`endif
    endtask

    task automatic test_mid_reset;
        int n;
        bit quiet;
        logic [6:0] exp;
        req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            req = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        compared++;
        if (target !== 7'd0) begin mismatched++; $display("[TB] FAIL midrst_target got=%0d want=0", target); end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        compared++;
        if (!quiet) begin mismatched++; $display("[TB] FAIL midrst_no_valid got=0 want=1"); end
        req = 1'b1;
        exp = ref_target(m_lfsr, 7'd0, 1, 99);
        wait_valid(1'b0, n);
        compared++;
        if (n != 18) begin mismatched++; $display("[TB] FAIL midrst_latency got=%0d want=18", n); end
        compared++;
        if (target !== exp) begin mismatched++; $display("[TB] FAIL midrst_target_new got=%0d want=%0d", target, exp); end
    endtask

    task automatic test_repeat_avoid;
        int n;
        logic [6:0] prev;
        rst_b = 1'b1; req_b = 1'b0;
        tick();
        tick();
        rst_b = 1'b0; req_b = 1'b1;
        prev = 7'd0;
        for (int k = 0; k < 10; k++) begin
            wait_valid(1'b1, n);
            compared++;
            if (n != ((k == 0) ? 18 : 19)) begin
                mismatched++; $display("[TB] FAIL repeat_spacing_%0d got=%0d want=%0d", k, n, (k == 0) ? 18 : 19);
            end
            compared++;
            if (target_b < 7'd1 || target_b > 7'd2) begin
                mismatched++; $display("[TB] FAIL repeat_range_%0d got=%0d want=1..2", k, target_b);
            end
            if (k == 0) begin
                compared++;
                if (target_b !== 7'd2) begin mismatched++; $display("[TB] FAIL repeat_first got=%0d want=2", target_b); end
            end else begin
                compared++;
                if (target_b === prev) begin
                    mismatched++; $display("[TB] FAIL repeat_alt_%0d got=%0d want!=%0d", k, target_b, prev);
                end
            end
            prev = target_b;
        end
        req_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0;
        rst_b = 1'b1; req_b = 1'b0;
        test_reset();
        test_first_request();
        test_ignored_req();
        test_mid_reset();
        test_repeat_avoid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
